// File: rtl/abus_gen.sv
// Address bus generator for the microcoded 65C02 core: holds AB, PC and the AHL latch.
// One cycle from ab_op/DB to AB, PC and AHL; rdy=0 holds all state. Optional ABUS_RESET_VECTOR_EN resets AB/PC to FFFC.
module abus_gen #(
    parameter logic [15:0] RESET_AB = 16'h0000,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic [12:0] ab_op,
    input  logic [7:0]  DB,
    input  logic [7:0]  REG,
    output logic [15:0] AB,
    output logic [15:0] PC,
    output logic        abl_co
);

`ifdef ABUS_RESET_VECTOR_EN
    localparam logic [15:0] AB_INIT = 16'hFFFC;
    localparam logic [15:0] PC_INIT = 16'hFFFC;
`else
    localparam logic [15:0] AB_INIT = RESET_AB;
    localparam logic [15:0] PC_INIT = RESET_PC;
`endif

    logic        pc_ld;
    logic        pc_inc;
    logic        ahl_ld;
    logic [1:0]  abh_sel;
    logic [1:0]  abh_mod;
    logic [2:0]  abl_b_sel;
    logic [1:0]  abl_a_sel;
    logic        abl_ci;

    logic [7:0]  ahl;
    logic [7:0]  abl_a;
    logic [7:0]  abl_b;
    logic [8:0]  abl_sum;
    logic [7:0]  abh_base;
    logic [7:0]  abh_next;
    logic [15:0] ab_next;
    logic [15:0] pc_next;

    assign pc_ld     = ab_op[12];
    assign pc_inc    = ab_op[11];
    assign ahl_ld    = ab_op[10];
    assign abh_sel   = ab_op[9:8];
    assign abh_mod   = ab_op[7:6];
    assign abl_b_sel = ab_op[5:3];
    assign abl_a_sel = ab_op[2:1];
    assign abl_ci    = ab_op[0];

    always_comb begin
        abl_a = 8'h00;
        case (abl_a_sel)
            2'b00:   abl_a = 8'h00;
            2'b01:   abl_a = DB;
            2'b10:   abl_a = PC[7:0];
            default: abl_a = AB[7:0];
        endcase
    end

    always_comb begin
        abl_b = 8'h00;
        case (abl_b_sel)
            3'b001:  abl_b = REG;
            3'b010:  abl_b = DB;
            3'b011:  abl_b = ahl;
            default: abl_b = 8'h00;
        endcase
    end

    assign abl_sum = {1'b0, abl_a} + {1'b0, abl_b} + {8'h00, abl_ci};
    assign abl_co  = abl_sum[8];

    always_comb begin
        abh_base = 8'h00;
        case (abh_sel)
            2'b01:   abh_base = PC[15:8];
            2'b10:   abh_base = AB[15:8];
            2'b11:   abh_base = DB;
            default: abh_base = 8'h00;
        endcase
    end

    // In constant mode the modifier bits pick the page instead of adjusting it.
    always_comb begin
        abh_next = 8'h00;
        if (abh_sel == 2'b00) begin
            case (abh_mod)
                2'b01:   abh_next = 8'h01;
                2'b11:   abh_next = 8'hFF;
                default: abh_next = 8'h00;
            endcase
        end else begin
            abh_next = abh_base
                     + {7'h00, abh_mod[1] & abl_co}
                     + (abh_mod[0] ? 8'hFF : 8'h00);
        end
    end

    assign ab_next = {abh_next, abl_sum[7:0]};
    assign pc_next = ab_next + {15'h0000, pc_inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            AB  <= AB_INIT;
            PC  <= PC_INIT;
            ahl <= 8'h00;
        end else if (rdy) begin
            AB <= ab_next;
            if (pc_ld)
                PC <= pc_next;
            if (ahl_ld)
                ahl <= DB;
        end
    end

endmodule

// File: tb/tb_abus_gen.sv
// Bench for abus_gen: directed vector table, hand sequences for stalls/reset, random run against a model.
module tb_abus_gen;

    logic        clk;
    logic        reset;
    logic        rdy;
    logic [12:0] ab_op;
    logic [7:0]  db;
    logic [7:0]  rg;
    logic [15:0] ab;
    logic [15:0] pc;
    logic        abl_co;

    int total = 0;
    int bad   = 0;

    abus_gen dut (
        .clk   (clk),
        .reset (reset),
        .rdy   (rdy),
        .ab_op (ab_op),
        .DB    (db),
        .REG   (rg),
        .AB    (ab),
        .PC    (pc),
        .abl_co(abl_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ABUS_RESET_VECTOR_EN
    localparam logic [15:0] EXP_RST = 16'hFFFC;
`else
    localparam logic [15:0] EXP_RST = 16'h0000;
`endif

    localparam logic [1:0] A_ZERO = 2'd0, A_DB = 2'd1, A_PCL = 2'd2, A_ABL = 2'd3;
    localparam logic [2:0] B_ZERO = 3'd0, B_REG = 3'd1, B_DB = 3'd2, B_AHL = 3'd3;
    localparam logic [1:0] H_CONST = 2'd0, H_PCH = 2'd1, H_ABH = 2'd2, H_DB = 2'd3;

    function automatic logic [12:0] mk(input logic ld, input logic inc, input logic ahl,
                                       input logic [1:0] hb, input logic [1:0] k,
                                       input logic [2:0] b, input logic [1:0] a, input logic ci);
        return {ld, inc, ahl, hb, k, b, a, ci};
    endfunction

    typedef struct {
        logic [12:0] op;
        logic [7:0]  db;
        logic [7:0]  rg;
        logic        rdy;
        logic        co;
        logic [15:0] ab;
        logic [15:0] pc;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle from a negedge, sample abl_co before the edge, return at the next negedge.
    task automatic step(input logic [12:0] op_v, input logic [7:0] db_v, input logic [7:0] rg_v,
                        input logic rdy_v, input logic rst_v, output logic co_v);
        ab_op = op_v;
        db    = db_v;
        rg    = rg_v;
        rdy   = rdy_v;
        reset = rst_v;
        #2;
        co_v = abl_co;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: the address rules as plain integer arithmetic.
    int m_ab, m_pc, m_ahl;

    function automatic void model(input logic [12:0] op, input int dbv, input int rgv,
                                  output int nxt, output int co);
        int a, b, lo, hi, base;
        case (op[2:1])
            2'd0: a = 0;
            2'd1: a = dbv;
            2'd2: a = m_pc % 256;
            default: a = m_ab % 256;
        endcase
        case (op[5:3])
            3'd1: b = rgv;
            3'd2: b = dbv;
            3'd3: b = m_ahl;
            default: b = 0;
        endcase
        lo = a + b + int'(op[0]);
        co = (lo >= 256) ? 1 : 0;
        if (op[9:8] == 2'd0) begin
            hi = (op[7:6] == 2'd1) ? 1 : (op[7:6] == 2'd3) ? 255 : 0;
        end else begin
            case (op[9:8])
                2'd1: base = m_pc / 256;
                2'd2: base = m_ab / 256;
                default: base = dbv;
            endcase
            hi = (base + ((op[7] && co == 1) ? 1 : 0) + (op[6] ? 255 : 0)) % 256;
        end
        nxt = hi * 256 + lo % 256;
    endfunction

    initial begin
        logic [12:0] hold_ahl, op_r;
        logic        co;
        int          nxt, eco;
        logic [7:0]  rdb, rrg;
        logic        rrdy, rrst;

        hold_ahl = mk(0, 0, 1, H_ABH, 2'd0, B_ZERO, A_ABL, 0);
        op_r     = mk(0, 0, 0, H_ABH, 2'd2, B_ZERO, A_ABL, 1);

        tbl[0]  = '{mk(1,0,1,H_CONST,2'd0,B_ZERO,A_ZERO,0), 8'hFF, 8'h00, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{mk(0,0,0,H_DB,2'd0,B_AHL,A_ZERO,0),     8'h12, 8'h00, 1'b1, 1'b0, 16'h12FF, 16'h0000};
        tbl[2]  = '{op_r,                                    8'h00, 8'h00, 1'b1, 1'b1, 16'h1300, 16'h0000};
        tbl[3]  = '{hold_ahl,                                8'hFF, 8'h00, 1'b1, 1'b0, 16'h1300, 16'h0000};
        tbl[4]  = '{mk(0,0,0,H_DB,2'd0,B_AHL,A_ZERO,0),     8'hFF, 8'h00, 1'b1, 1'b0, 16'hFFFF, 16'h0000};
        tbl[5]  = '{op_r,                                    8'h00, 8'h00, 1'b1, 1'b1, 16'h0000, 16'h0000};
        tbl[6]  = '{hold_ahl,                                8'h05, 8'h00, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[7]  = '{mk(0,0,0,H_DB,2'd0,B_AHL,A_ZERO,0),     8'h12, 8'h00, 1'b1, 1'b0, 16'h1205, 16'h0000};
        tbl[8]  = '{mk(0,0,0,H_ABH,2'd3,B_DB,A_ABL,1),      8'hF0, 8'h00, 1'b1, 1'b0, 16'h11F6, 16'h0000};
        tbl[9]  = '{mk(0,0,0,H_ABH,2'd3,B_DB,A_ABL,0),      8'h20, 8'h00, 1'b1, 1'b1, 16'h1116, 16'h0000};
        tbl[10] = '{hold_ahl,                                8'h34, 8'h00, 1'b1, 1'b0, 16'h1116, 16'h0000};
        tbl[11] = '{mk(1,1,0,H_DB,2'd0,B_AHL,A_ZERO,0),     8'h12, 8'h05, 1'b1, 1'b0, 16'h1234, 16'h1235};
        tbl[12] = '{mk(0,0,0,H_CONST,2'd1,B_REG,A_ZERO,1),  8'h00, 8'hFF, 1'b1, 1'b1, 16'h0100, 16'h1235};
        tbl[13] = '{mk(1,1,0,H_PCH,2'd0,B_ZERO,A_PCL,0),    8'h00, 8'h00, 1'b1, 1'b0, 16'h1235, 16'h1236};
        tbl[14] = '{mk(1,1,1,H_CONST,2'd3,B_DB,A_DB,0),     8'h80, 8'h00, 1'b0, 1'b1, 16'h1235, 16'h1236};
        tbl[15] = '{mk(0,0,0,H_CONST,2'd0,B_AHL,A_ZERO,0),  8'h00, 8'h05, 1'b1, 1'b0, 16'h0034, 16'h1236};
        tbl[16] = '{mk(0,0,1,H_CONST,2'd0,B_AHL,A_ZERO,0),  8'h77, 8'h00, 1'b1, 1'b0, 16'h0034, 16'h1236};
        tbl[17] = '{mk(0,0,0,H_CONST,2'd0,B_AHL,A_ZERO,0),  8'h00, 8'h00, 1'b1, 1'b0, 16'h0077, 16'h1236};

        reset = 1'b1; rdy = 1'b0; ab_op = '0; db = '0; rg = '0;
        @(negedge clk);

        // Reset state, with rdy low and a busy op to show reset priority.
        step(mk(1,1,1,H_DB,2'd3,B_DB,A_DB,1), 8'hA5, 8'h5A, 1'b0, 1'b1, co);
        chk("reset_ab", ab, EXP_RST);
        chk("reset_pc", pc, EXP_RST);
        step(mk(0,0,0,H_CONST,2'd0,B_AHL,A_ZERO,0), 8'h55, 8'h00, 1'b1, 1'b0, co);
        chk("reset_ahl", ab, 16'h0000);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].op, tbl[i].db, tbl[i].rg, tbl[i].rdy, 1'b0, co);
            chk($sformatf("vec%0d_co", i), {15'h0, co}, {15'h0, tbl[i].co});
            chk($sformatf("vec%0d_ab", i), ab, tbl[i].ab);
            chk($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
        end

        // Absolute,X second cycle stalled for three cycles.
        step(mk(1,0,0,H_CONST,2'd3,B_ZERO,A_ZERO,0), 8'h00, 8'h00, 1'b1, 1'b0, co);
        chk("stall_pre_ab", ab, 16'hFF00);
        step(hold_ahl, 8'h34, 8'h00, 1'b1, 1'b0, co);
        for (int i = 0; i < 3; i++) begin
            step(mk(1,1,0,H_DB,2'd0,B_AHL,A_ZERO,0), 8'h12, 8'h05, 1'b0, 1'b0, co);
            chk($sformatf("stall%0d_ab", i), ab, 16'hFF00);
            chk($sformatf("stall%0d_pc", i), pc, 16'hFF00);
        end
        step(mk(1,1,0,H_DB,2'd0,B_AHL,A_ZERO,0), 8'h12, 8'h05, 1'b1, 1'b0, co);
        chk("stall_done_ab", ab, 16'h1234);
        chk("stall_done_pc", pc, 16'h1235);

        // Reset in the middle of a load discards the pending PC/AHL update.
        step(mk(1,1,1,H_DB,2'd0,B_DB,A_DB,0), 8'hC3, 8'h00, 1'b1, 1'b1, co);
        chk("midrst_ab", ab, EXP_RST);
        chk("midrst_pc", pc, EXP_RST);
        step(mk(0,0,0,H_CONST,2'd0,B_AHL,A_ZERO,0), 8'h00, 8'h00, 1'b1, 1'b0, co);
        chk("midrst_ahl", ab, 16'h0000);

        m_ab = 0; m_pc = int'(EXP_RST); m_ahl = 0;
        for (int i = 0; i < 800; i++) begin
            op_r = 13'($urandom);
            rdb  = 8'($urandom);
            rrg  = 8'($urandom);
            rrdy = ($urandom_range(0, 3) != 0);
            rrst = ($urandom_range(0, 31) == 0);
            model(op_r, int'(rdb), int'(rrg), nxt, eco);
            step(op_r, rdb, rrg, rrdy, rrst, co);
            if (rrst) begin
                m_ab = int'(EXP_RST); m_pc = int'(EXP_RST); m_ahl = 0;
            end else if (rrdy) begin
                if (op_r[12]) m_pc = (nxt + int'(op_r[11])) % 65536;
                if (op_r[10]) m_ahl = int'(rdb);
                m_ab = nxt;
            end
            chk("rand_co", {15'h0, co}, 16'(eco));
            chk("rand_ab", ab, 16'(m_ab));
            chk("rand_pc", pc, 16'(m_pc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
